collision_scheduler: RTL and testbench
======================================

Name: collision_scheduler

Overview:
Time-multiplexes one shared combinational box-overlap comparator (center x/y, height/width, 10-bit) across up to N_OBJ scene objects once per frame. Each frame it tests a reference object (the player) against every active table entry. It fetches each entry from the object table over a 1-cycle-latency read port and drives the comparator's operands from registers. It collects a per-object hit mask, which game logic reads after `done`.

Parameters:
N_OBJ, 8, number of object-table entries scanned (2..64)
IDX_W, 3, width of object index; must satisfy 2**IDX_W >= N_OBJ

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  1-cycle start pulse, once per frame
obj_active  in  N_OBJ  per-entry enable; sampled on start
ref_x, ref_y  in  10  reference object center; latched on start
ref_h, ref_w  in  10  reference object height/width; latched on start
obj_idx  out  IDX_W  object-table read address
obj_x, obj_y, obj_h, obj_w  in  10 each  table read data; valid 1 cycle after obj_idx is presented
cmp_f_x, cmp_f_y, cmp_f_h, cmp_f_w  out  10 each  comparator first-object operands (registered)
cmp_s_x, cmp_s_y, cmp_s_h, cmp_s_w  out  10 each  comparator second-object operands (registered)
cmp_hit  in  1  comparator result (combinational from cmp_* outputs)
hit_mask  out  N_OBJ  result of last completed scan; bit i = object i overlaps reference
any_hit  out  1  OR of hit_mask
busy  out  1  scan in progress
done  out  1  1-cycle pulse when hit_mask updates
overrun  out  1  1-cycle pulse: frame_tick arrived while busy

Behaviour:
- Reset: state IDLE. All outputs 0: obj_idx, cmp_*, hit_mask, any_hit, busy, done, overrun. Internal index and working mask 0. Reset mid-scan aborts the scan; the previous hit_mask is discarded (becomes 0).
- FSM states: IDLE, ADDR, DATA, CHECK.
- IDLE:
  - On frame_tick, latch ref_* into cmp_f_*, latch obj_active, clear the working mask, set idx=0, busy=1, go to ADDR.
  - Otherwise hold. hit_mask holds its value between scans.
- ADDR: drive obj_idx=idx.
  - If latched active[idx]=0: working[idx]=0, then advance.
  - Else go to DATA.
- DATA: register obj_x/y/h/w into cmp_s_*, then go to CHECK.
- CHECK: working[idx] <= cmp_hit, then advance.
- Advance rule:
  - If idx==N_OBJ-1: hit_mask <= working (including this cycle's update), any_hit <= |working, done=1 for one cycle, busy=0, go to IDLE.
  - Else idx+1 -> ADDR.
- Timing: with A active and S inactive entries (A+S=N_OBJ), done is high in the cycle after the 3A+S-th clock edge following the edge that samples frame_tick. Inactive entries cost 1 cycle each; active entries cost 3. No wrap of idx beyond N_OBJ-1.
- frame_tick while busy: ignored; the scan continues unchanged; overrun pulses for 1 cycle.
- frame_tick in the same cycle that done is asserted: the FSM is already IDLE, so the tick is accepted and a new scan starts.
- obj_active and ref_* changes during a scan have no effect on the current scan.
- cmp_* outputs stay stable between updates; cmp_hit is sampled only in CHECK.

Optional Feature:
COLL_EARLY_EXIT_EN
- Defined: in CHECK, if cmp_hit=1 the scan terminates immediately with done. hit_mask has only that (lowest-index) bit set; remaining bits are 0.
- Undefined: the full scan always runs, and all overlapping bits are reported.

Test Plan:
- Reset, then all 8 entries active, none overlapping (ref at 100,100 size 10x10; objects at x=300) -> done exactly 24 edges after tick, hit_mask=0x00, any_hit=0.
- Same setup, objects 2 and 5 placed at 104,104 size 10x10 -> hit_mask=0x24, any_hit=1, single-cycle done.
- obj_active=0x00 -> done 8 edges after tick, hit_mask=0x00, obj_idx steps 0..7 one per cycle.
- Second frame_tick 5 cycles into a scan -> overrun pulses once, done timing unchanged, exactly one done.
- reset asserted 10 cycles into a scan -> busy=0, hit_mask=0, no done; the next tick completes normally.
- With COLL_EARLY_EXIT_EN, objects 2 and 5 overlapping -> done 9 edges after tick, hit_mask=0x04.

Source files
------------

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Shares one combinational box-overlap comparator across N_OBJ object-table
//   entries. Once per frame it tests the reference object against every
//   active entry. It fetches each entry over a 1-cycle-latency read port and
//   collects a per-object hit mask.
//
//   Build option: COLL_EARLY_EXIT_EN. When it is defined, the scan stops at
//   the first overlapping entry, and hit_mask holds only that entry's bit.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   frame_tick          1-cycle start pulse
//   obj_active          per-entry enable, sampled on start
//   ref_x/y/h/w         reference box, latched on start
//   obj_idx             object-table read address
//   obj_x/y/h/w         table read data, valid 1 cycle after obj_idx
//   cmp_f_*/cmp_s_*     registered comparator operands (reference / entry)
//   cmp_hit             comparator result
//   hit_mask, any_hit   result of the last completed scan
//   busy, done, overrun scan status; done/overrun are 1-cycle pulses
module collision_scheduler #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [N_OBJ-1:0] obj_active,
    input  logic [9:0]       ref_x,
    input  logic [9:0]       ref_y,
    input  logic [9:0]       ref_h,
    input  logic [9:0]       ref_w,
    output logic [IDX_W-1:0] obj_idx,
    input  logic [9:0]       obj_x,
    input  logic [9:0]       obj_y,
    input  logic [9:0]       obj_h,
    input  logic [9:0]       obj_w,
    output logic [9:0]       cmp_f_x,
    output logic [9:0]       cmp_f_y,
    output logic [9:0]       cmp_f_h,
    output logic [9:0]       cmp_f_w,
    output logic [9:0]       cmp_s_x,
    output logic [9:0]       cmp_s_y,
    output logic [9:0]       cmp_s_h,
    output logic [9:0]       cmp_s_w,
    input  logic             cmp_hit,
    output logic [N_OBJ-1:0] hit_mask,
    output logic             any_hit,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CHECK} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [N_OBJ-1:0] active;
    logic [N_OBJ-1:0] working;
    logic [N_OBJ-1:0] wnext;
    logic             last;
    logic             step;
    logic             early;

    assign obj_idx = idx;
    assign last    = (idx == IDX_W'(N_OBJ - 1));

    // An entry is finished either in ADDR (inactive) or in CHECK.
    assign step = ((state == ADDR) && !active[idx]) || (state == CHECK);

`ifdef COLL_EARLY_EXIT_EN
    assign early = (state == CHECK) && cmp_hit;
`else
    assign early = 1'b0;
`endif

    // Working mask including this cycle's result, so the final entry's
    // result goes into hit_mask in the same cycle that finishes the scan.
    always_comb begin
        wnext = working;
        case (state)
            ADDR:    if (!active[idx]) wnext[idx] = 1'b0;
            CHECK:   wnext[idx] = cmp_hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            active   <= '0;
            working  <= '0;
            cmp_f_x  <= '0;
            cmp_f_y  <= '0;
            cmp_f_h  <= '0;
            cmp_f_w  <= '0;
            cmp_s_x  <= '0;
            cmp_s_y  <= '0;
            cmp_s_h  <= '0;
            cmp_s_w  <= '0;
            hit_mask <= '0;
            any_hit  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= frame_tick && (state != IDLE);

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        cmp_f_x <= ref_x;
                        cmp_f_y <= ref_y;
                        cmp_f_h <= ref_h;
                        cmp_f_w <= ref_w;
                        active  <= obj_active;
                        working <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (active[idx]) state <= DATA;
                end
                DATA: begin
                    cmp_s_x <= obj_x;
                    cmp_s_y <= obj_y;
                    cmp_s_h <= obj_h;
                    cmp_s_w <= obj_w;
                    state   <= CHECK;
                end
                default: ;
            endcase

            if (step) begin
                working <= wnext;
                if (last || early) begin
                    hit_mask <= wnext;
                    any_hit  <= |wnext;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ADDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler
//   Bench for collision_scheduler. It provides the object table (1-cycle read
//   latency) and the overlap comparator, and it keeps a per-scan reference
//   model of busy/done/overrun/hit_mask/any_hit. It runs directed scenarios
//   with literal expectations, followed by randomized frames.
//   The bench follows COLL_EARLY_EXIT_EN in the same way as the design.
module tb_collision_scheduler;

    localparam int N = 8;
    localparam int W = 3;

`ifdef COLL_EARLY_EXIT_EN
    localparam int          LAT_HIT  = 9;
    localparam logic [7:0]  MASK_HIT = 8'h04;
    localparam int          RST_AT   = 5;
`else
    localparam int          LAT_HIT  = 24;
    localparam logic [7:0]  MASK_HIT = 8'h24;
    localparam int          RST_AT   = 10;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_tick;
    logic [N-1:0] obj_active;
    logic [9:0]   ref_x, ref_y, ref_h, ref_w;
    logic [W-1:0] obj_idx;
    logic [9:0]   obj_x, obj_y, obj_h, obj_w;
    logic [9:0]   cmp_f_x, cmp_f_y, cmp_f_h, cmp_f_w;
    logic [9:0]   cmp_s_x, cmp_s_y, cmp_s_h, cmp_s_w;
    logic         cmp_hit;
    logic [N-1:0] hit_mask;
    logic         any_hit, busy, done, overrun;

    collision_scheduler #(.N_OBJ(N), .IDX_W(W)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .obj_active(obj_active),
        .ref_x(ref_x), .ref_y(ref_y), .ref_h(ref_h), .ref_w(ref_w),
        .obj_idx(obj_idx),
        .obj_x(obj_x), .obj_y(obj_y), .obj_h(obj_h), .obj_w(obj_w),
        .cmp_f_x(cmp_f_x), .cmp_f_y(cmp_f_y), .cmp_f_h(cmp_f_h), .cmp_f_w(cmp_f_w),
        .cmp_s_x(cmp_s_x), .cmp_s_y(cmp_s_y), .cmp_s_h(cmp_s_h), .cmp_s_w(cmp_s_w),
        .cmp_hit(cmp_hit), .hit_mask(hit_mask), .any_hit(any_hit),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Object table with a 1-cycle read latency
    logic [9:0] tab_x [N];
    logic [9:0] tab_y [N];
    logic [9:0] tab_h [N];
    logic [9:0] tab_w [N];

    always @(posedge clk) begin
        obj_x <= tab_x[obj_idx];
        obj_y <= tab_y[obj_idx];
        obj_h <= tab_h[obj_idx];
        obj_w <= tab_w[obj_idx];
    end

    // Center/size boxes overlap when the center distance on each axis is
    // below half the summed extents (w spans x, h spans y).
    function automatic bit overlap(input int fx, input int fy, input int fh, input int fw,
                                   input int sx, input int sy, input int sh, input int sw);
        int dx = fx - sx;
        int dy = fy - sy;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (2 * dx < fw + sw) && (2 * dy < fh + sh);
    endfunction

    assign cmp_hit = overlap(cmp_f_x, cmp_f_y, cmp_f_h, cmp_f_w,
                             cmp_s_x, cmp_s_y, cmp_s_h, cmp_s_w);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model computes the cost and the mask of a whole frame when the
    // frame starts. It then counts down the edges until done.
    bit           m_busy, m_done, m_ov, m_any;
    logic [N-1:0] m_mask, m_pend;
    int           m_cnt;
    logic [9:0]   m_fx, m_fy;
    bit           chk_en = 1'b0;

    function automatic void plan(input logic [N-1:0] act, output logic [N-1:0] mask,
                                 output int cost);
        mask = '0;
        cost = 0;
        for (int i = 0; i < N; i++) begin
            if (!act[i]) begin
                cost += 1;
            end else begin
                cost += 3;
                if (overlap(ref_x, ref_y, ref_h, ref_w, tab_x[i], tab_y[i], tab_h[i], tab_w[i])) begin
                    mask[i] = 1'b1;
`ifdef COLL_EARLY_EXIT_EN
                    break;
`endif
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_ov = 0; m_any = 0;
            m_mask = '0; m_cnt = 0;
        end else begin
            m_done = 0;
            m_ov   = 0;
            if (m_busy) begin
                m_ov  = frame_tick;
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_mask = m_pend;
                    m_any  = |m_pend;
                end
            end else if (frame_tick) begin
                plan(obj_active, m_pend, m_cnt);
                m_fx   = ref_x;
                m_fy   = ref_y;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("overrun", overrun, m_ov);
            check("hit_mask", hit_mask, m_mask);
            check("any_hit", any_hit, m_any);
            if (m_busy) begin
                check("cmp_f_x", cmp_f_x, m_fx);
                check("cmp_f_y", cmp_f_y, m_fy);
            end
        end
    end

    // ---------------- stimulus ----------------
    int ov_cnt, dn_cnt;
    int idx_log [64];

    task automatic start_scan();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Called at the negedge after the start edge. It returns the number of
    // edges from the start edge to the edge that raised done.
    task automatic wait_done(input int inj, input bit chaos, output int edges);
        int n = 0;
        ov_cnt = 0;
        dn_cnt = 0;
        idx_log[0] = int'(obj_idx);
        while (n < 200) begin
            @(negedge clk);
            n++;
            frame_tick = 1'b0;
            if (n < 64) idx_log[n] = int'(obj_idx);
            if (overrun) ov_cnt++;
            if (done) begin
                dn_cnt++;
                break;
            end
            if (n == inj) frame_tick = 1'b1;
            if (chaos) begin
                obj_active = N'($urandom);
                ref_x      = 10'($urandom);
                ref_y      = 10'($urandom);
                frame_tick = ($urandom_range(0, 7) == 0);
            end
        end
        edges = n;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done after %0d edges at %0t", n, $time);
        end
    endtask

    task automatic setup_far();
        ref_x = 10'd100; ref_y = 10'd100; ref_h = 10'd10; ref_w = 10'd10;
        for (int i = 0; i < N; i++) begin
            tab_x[i] = 10'd300; tab_y[i] = 10'd100; tab_h[i] = 10'd10; tab_w[i] = 10'd10;
        end
    endtask

    initial begin
        int e;
        reset      = 1'b1;
        frame_tick = 1'b0;
        obj_active = '0;
        setup_far();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_mask", hit_mask, 8'h00);
        check("rst_idx", obj_idx, 3'd0);
        check("rst_cmp_s_x", cmp_s_x, 10'd0);
        reset = 1'b0;
        @(negedge clk);

        // all active, no overlap
        obj_active = 8'hFF;
        start_scan();
        wait_done(-1, 0, e);
        check("t1_latency", e, 24);
        check("t1_mask", hit_mask, 8'h00);
        check("t1_any", any_hit, 1'b0);

        // objects 2 and 5 overlap
        tab_x[2] = 10'd104; tab_y[2] = 10'd104;
        tab_x[5] = 10'd104; tab_y[5] = 10'd104;
        start_scan();
        wait_done(-1, 0, e);
        check("t2_latency", e, LAT_HIT);
        check("t2_mask", hit_mask, MASK_HIT);
        check("t2_any", any_hit, 1'b1);
        @(negedge clk);
        check("t2_done_1cyc", done, 1'b0);

        // all inactive: one cycle per entry, address walks 0..7
        obj_active = 8'h00;
        start_scan();
        wait_done(-1, 0, e);
        check("t3_latency", e, 8);
        check("t3_mask", hit_mask, 8'h00);
        for (int k = 0; k < 8; k++) check("t3_idx_walk", idx_log[k], k);

        // second tick 5 cycles into a scan
        obj_active = 8'hFF;
        start_scan();
        wait_done(5, 0, e);
        check("t4_latency", e, LAT_HIT);
        repeat (4) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        check("t4_overrun_cnt", ov_cnt, 1);
        check("t4_done_cnt", dn_cnt, 1);
        check("t4_mask", hit_mask, MASK_HIT);

        // reset mid-scan discards the previous result
        start_scan();
        repeat (RST_AT) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_mask", hit_mask, 8'h00);
        dn_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        check("t5_no_done", dn_cnt, 0);
        start_scan();
        wait_done(-1, 0, e);
        check("t5_resume_lat", e, LAT_HIT);
        check("t5_resume_mask", hit_mask, MASK_HIT);

        // randomized frames; each tick is issued in the cycle done is high
        repeat (40) begin
            int rx = int'($urandom_range(200, 300));
            int ry = int'($urandom_range(200, 300));
            ref_x = 10'(rx);
            ref_y = 10'(ry);
            ref_h = 10'($urandom_range(1, 40));
            ref_w = 10'($urandom_range(1, 40));
            for (int i = 0; i < N; i++) begin
                tab_x[i] = 10'(rx + int'($urandom_range(0, 60)) - 30);
                tab_y[i] = 10'(ry + int'($urandom_range(0, 60)) - 30);
                tab_h[i] = 10'($urandom_range(1, 40));
                tab_w[i] = 10'($urandom_range(1, 40));
            end
            obj_active = N'($urandom);
            start_scan();
            wait_done(-1, 1, e);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
